goose_vga_timing: RTL and testbench
===================================

Name: goose_vga_timing

Overview:
- Upstream timing stage for the goose display path. Generates 640x480@60 VGA sync from a 25.175 MHz pixel clock (25 MHz acceptable).
- Provides pixel coordinates, display-enable, a per-frame tick and a free-running frame counter.
- The downstream pixel/animation stage consumes these outputs and drives colour plus sync onto uo_out.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- FRAME_W, 8, width of frame_cnt

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  advance enable; when 0, all state holds
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- frame_tick  out  1  one-cycle pulse on entry to (0,0) after a full frame
- frame_cnt  out  FRAME_W  frames completed, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params = 800; V_TOTAL = 525.
- Reset (async assert, sync release): hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_tick=0, frame_cnt=0.
- Clock domain: one clock only. Every output is a flop, with no combinational path from run to any output.
- Sync alignment: hsync, vsync and display_on are computed from the next-state counter values, so they match hpos/vpos in the same cycle. Latency from counter to sync is 0 cycles.
- Horizontal counting: on each clk with run=1, hpos increments. At hpos=H_TOTAL-1 it wraps to 0 and vpos advances.
- Vertical counting: vpos increments on each hpos wrap. On an hpos wrap when vpos=V_TOTAL-1, vpos wraps to 0.
- hsync is low iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. hpos 656..751.
- vsync is low iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. vpos 490..491. This depends on vpos only, not on hpos.
- frame_tick is high for exactly the one cycle where hpos=0 and vpos=0 after the wrap from (799,524). It is never high after reset until the first full frame completes.
- frame_cnt increments in the same cycle frame_tick rises, and wraps 255 -> 0.
- run=0: hpos, vpos, sync outputs and frame_cnt hold. frame_tick is forced to 0, even if stalled at (0,0).
- run toggling: resuming continues from the held position with no skipped or duplicated pixels.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). Counting restarts at (0,0) with no frame_tick.
- Width rule: counters are 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal and are rejected by elaboration-time assertion.

Decomposition:
- Shared package goose_vga_pkg holds:
  - the default timing constants and H_TOTAL/V_TOTAL;
  - a coordinate typedef (10-bit unsigned);
  - a struct bundling hpos, vpos, hsync, vsync and display_on, for passing to the pixel stage.
- No sub-module. The two counters are simple enough to inline.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-line at hpos=300 -> all outputs take reset values without a clock edge. After release, first run cycle gives hpos=1, vpos=0.
- Horizontal line: run=1 for 800 cycles -> hsync low exactly at hpos 656..751 (96 cycles). Wrap 799 -> 0 with vpos 0 -> 1. display_on falls at hpos 640.
- Full frame: run 420000 cycles -> vsync low for 1600 cycles at vpos 490..491. frame_tick pulses once, at cycle 420000. frame_cnt=1.
- Stall: deassert run at (655,489) for 10 cycles -> outputs frozen; resume gives (656,489) with hsync=0.
- Counter wrap: run 256 frames -> frame_cnt wraps 255 -> 0 coincident with the 256th frame_tick.
- Stall at frame start: stall at (0,0) right after a tick -> frame_tick stays 0 throughout and does not re-pulse on resume.

Source files
------------

// File: rtl/goose_vga_pkg.sv
// Shared timing constants and types for the goose display path.
// The pixel stage imports this to receive the bundled sync/coordinate record.
package goose_vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t hpos;
    coord_t vpos;
    logic   hsync;
    logic   vsync;
    logic   display_on;
  } vga_timing_t;

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/goose_vga_timing.sv
// 640x480@60 VGA timing generator: pixel/line counters, active-low syncs,
// display enable, per-frame tick and a wrapping frame counter.
module goose_vga_timing
  import goose_vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("goose_vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  vga_timing_t        timing_q, timing_d;
  logic               frameWrap_d;
  logic               frameTick_q;
  logic [FRAME_W-1:0] frameCnt_q;

  // Syncs are decoded from the next coordinates so they land in the same
  // register stage as the position they describe.
  always_comb begin
    timing_d    = timing_q;
    frameWrap_d = 1'b0;
    if (timing_q.hpos == H_LAST) begin
      timing_d.hpos = '0;
      if (timing_q.vpos == V_LAST) begin
        timing_d.vpos = '0;
        frameWrap_d   = 1'b1;
      end else begin
        timing_d.vpos = timing_q.vpos + coord_t'(1);
      end
    end else begin
      timing_d.hpos = timing_q.hpos + coord_t'(1);
    end
    timing_d.hsync      = ~in_window(timing_d.hpos, HS_START, HS_END);
    timing_d.vsync      = ~in_window(timing_d.vpos, VS_START, VS_END);
    timing_d.display_on = (timing_d.hpos < H_VIS) && (timing_d.vpos < V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timing_q.hpos       <= '0;
      timing_q.vpos       <= '0;
      timing_q.hsync      <= 1'b1;
      timing_q.vsync      <= 1'b1;
      timing_q.display_on <= 1'b1;
      frameTick_q         <= 1'b0;
      frameCnt_q          <= '0;
    end else if (run) begin
      timing_q    <= timing_d;
      frameTick_q <= frameWrap_d;
      if (frameWrap_d) begin
        frameCnt_q <= frameCnt_q + FRAME_W'(1);
      end
    end else begin
      // A stall parked on (0,0) must not stretch or repeat the tick.
      frameTick_q <= 1'b0;
    end
  end

  assign hpos       = timing_q.hpos;
  assign vpos       = timing_q.vpos;
  assign hsync      = timing_q.hsync;
  assign vsync      = timing_q.vsync;
  assign display_on = timing_q.display_on;
  assign frame_tick = frameTick_q;
  assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_goose_vga_timing.sv
// Self-checking bench: a default-timing instance for line-level checks and a
// shrunken-timing instance for frame-level checks against a scoreboard model.
module tb_goose_vga_timing;
  import goose_vga_pkg::*;

  localparam int BH_DISP = 8, BH_FRONT = 2, BH_SYNC = 3, BH_BACK = 2;
  localparam int BV_DISP = 6, BV_FRONT = 1, BV_SYNC = 2, BV_BACK = 2;
  localparam int BH_TOTAL = BH_DISP + BH_FRONT + BH_SYNC + BH_BACK;
  localparam int BV_TOTAL = BV_DISP + BV_FRONT + BV_SYNC + BV_BACK;
  localparam int B_FRAME  = BH_TOTAL * BV_TOTAL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic runA = 1'b0;
  logic runB = 1'b0;

  logic [9:0] hposA, vposA, hposB, vposB;
  logic hsyncA, vsyncA, deA, tickA, hsyncB, vsyncB, deB, tickB;
  logic [7:0] cntA, cntB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  goose_vga_timing dutA (
    .clk(clk), .rst_n(rst_n), .run(runA),
    .hpos(hposA), .vpos(vposA), .hsync(hsyncA), .vsync(vsyncA),
    .display_on(deA), .frame_tick(tickA), .frame_cnt(cntA)
  );

  goose_vga_timing #(
    .H_DISPLAY(BH_DISP), .H_FRONT(BH_FRONT), .H_SYNC(BH_SYNC), .H_BACK(BH_BACK),
    .V_DISPLAY(BV_DISP), .V_FRONT(BV_FRONT), .V_SYNC(BV_SYNC), .V_BACK(BV_BACK),
    .FRAME_W(8)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .run(runB),
    .hpos(hposB), .vpos(vposB), .hsync(hsyncB), .vsync(vsyncB),
    .display_on(deB), .frame_tick(tickB), .frame_cnt(cntB)
  );

  typedef struct {
    int   adv;
    logic run;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic de;
    logic tk;
  } vecA_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       tk;
    logic [7:0] cnt;
  } expB_t;

  expB_t sbQ[$];
  int mH = 0, mV = 0, mCnt = 0;
  int tickCountB = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_hpos"}, 32'(hposA), 0);
    checkOutput({tag, "_vpos"}, 32'(vposA), 0);
    checkOutput({tag, "_hsync"}, 32'(hsyncA), 1);
    checkOutput({tag, "_vsync"}, 32'(vsyncA), 1);
    checkOutput({tag, "_de"}, 32'(deA), 1);
    checkOutput({tag, "_tick"}, 32'(tickA), 0);
    checkOutput({tag, "_cnt"}, 32'(cntA), 0);
  endtask

  // Drive one cycle on instance B, predict its outputs, then compare.
  task automatic applyStimulus(input logic r);
    expB_t e;
    expB_t act;
    logic  mTick;
    mTick = 1'b0;
    runB = r;
    if (r) begin
      if (mH == BH_TOTAL - 1) begin
        mH = 0;
        if (mV == BV_TOTAL - 1) begin
          mV = 0;
          mTick = 1'b1;
          mCnt = (mCnt + 1) % 256;
        end else begin
          mV = mV + 1;
        end
      end else begin
        mH = mH + 1;
      end
    end
    e.h   = 10'(mH);
    e.v   = 10'(mV);
    e.hs  = !(mH >= BH_DISP + BH_FRONT && mH < BH_DISP + BH_FRONT + BH_SYNC);
    e.vs  = !(mV >= BV_DISP + BV_FRONT && mV < BV_DISP + BV_FRONT + BV_SYNC);
    e.de  = (mH < BH_DISP) && (mV < BV_DISP);
    e.tk  = mTick;
    e.cnt = 8'(mCnt);
    sbQ.push_back(e);
    @(negedge clk);
    act = {hposB, vposB, hsyncB, vsyncB, deB, tickB, cntB};
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL sbEmpty: got empty queue, expected an entry");
    end else begin
      e = sbQ.pop_front();
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL sbB: got h=%0d v=%0d hs=%b vs=%b de=%b tk=%b cnt=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b tk=%b cnt=%0d",
                 act.h, act.v, act.hs, act.vs, act.de, act.tk, act.cnt,
                 e.h, e.v, e.hs, e.vs, e.de, e.tk, e.cnt);
      end
    end
    if (tickB === 1'b1) begin
      tickCountB++;
      if (tickCountB == 255) checkOutput("cntAt255", 32'(cntB), 255);
      if (tickCountB == 256) checkOutput("cntWrap", 32'(cntB), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecA_t vecs[12];
    int    lowCount;
    int    firstLow;
    int    ticks;
    int    vsLow;
    int    guard;

    vecs[0]  = '{1,   1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{638, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1,   1'b1, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{15,  1'b1, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1,   1'b1, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{5,   1'b0, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{95,  1'b1, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1,   1'b1, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{47,  1'b1, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1,   1'b1, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{799, 1'b1, 799, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1,   1'b1, 0,   2, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    checkReset("rst0");
    rst_n = 1'b1;
    runA  = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("preRstHpos", 32'(hposA), 300);

    // Asynchronous reset: sampled 1 ns after assertion, well before any edge.
    rst_n = 1'b0;
    #1;
    checkReset("rstMid");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runA = vecs[i].run;
      repeat (vecs[i].adv) @(negedge clk);
      checkOutput($sformatf("vecA%0d_hpos", i), 32'(hposA), 32'(vecs[i].h));
      checkOutput($sformatf("vecA%0d_vpos", i), 32'(vposA), 32'(vecs[i].v));
      checkOutput($sformatf("vecA%0d_hsync", i), 32'(hsyncA), 32'(vecs[i].hs));
      checkOutput($sformatf("vecA%0d_vsync", i), 32'(vsyncA), 32'(vecs[i].vs));
      checkOutput($sformatf("vecA%0d_de", i), 32'(deA), 32'(vecs[i].de));
      checkOutput($sformatf("vecA%0d_tick", i), 32'(tickA), 32'(vecs[i].tk));
      checkOutput($sformatf("vecA%0d_cnt", i), 32'(cntA), 0);
    end

    lowCount = 0;
    firstLow = -1;
    runA = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (hsyncA === 1'b0) begin
        lowCount++;
        if (firstLow < 0) firstLow = int'(hposA);
      end
    end
    checkOutput("lineHsyncLow", 32'(lowCount), 96);
    checkOutput("lineFirstLow", 32'(firstLow), 656);
    checkOutput("lineEndVpos", 32'(vposA), 3);
    runA = 1'b0;

    for (int i = 0; i < 600; i++) applyStimulus(logic'($urandom_range(9, 0) != 0));

    guard = 0;
    while (tickB !== 1'b1 && guard < 2 * B_FRAME) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("alignTick", 32'(tickB), 1);
    ticks = 0;
    vsLow = 0;
    for (int i = 0; i < B_FRAME; i++) begin
      applyStimulus(1'b1);
      if (tickB === 1'b1) ticks++;
      if (vsyncB === 1'b0) vsLow++;
    end
    checkOutput("frameTicks", 32'(ticks), 1);
    checkOutput("frameVsyncLow", 32'(vsLow), 2 * BH_TOTAL);

    guard = 0;
    while (!(mH == BH_DISP + BH_FRONT - 1 && mV == BV_DISP + BV_FRONT - 1) && guard < 2 * B_FRAME) begin
      applyStimulus(1'b1);
      guard++;
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("resumeHpos", 32'(hposB), BH_DISP + BH_FRONT);
    checkOutput("resumeVpos", 32'(vposB), BV_DISP + BV_FRONT - 1);
    checkOutput("resumeHsync", 32'(hsyncB), 0);

    guard = 0;
    while (tickB !== 1'b1 && guard < 2 * B_FRAME) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("stallTickSeen", 32'(tickB), 1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      if (tickB !== 1'b0) ticks++;
    end
    checkOutput("stallTickHeld", 32'(ticks), 0);
    applyStimulus(1'b1);
    checkOutput("stallResumeHpos", 32'(hposB), 1);
    checkOutput("stallResumeTick", 32'(tickB), 0);

    guard = 0;
    while (tickCountB < 256 && guard < 260 * B_FRAME) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("wrapReached", 32'(tickCountB), 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
